// File: rtl/move_commit.sv
// Move commit engine: checks the target board cell, writes the tile,
// tracks the board bounding box and reports the committed move to the host.
module move_commit #(
    parameter int x_width  = 10,
    parameter int depth    = 21,
    parameter int init_off = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               w_end,
    input  logic [x_width:0]   in_x,
    input  logic [x_width:0]   in_y,
    input  logic [3:0]         in_t,
    output logic               array_busy,
    output logic               ram_rd_en,
    output logic               ram_write_en,
    output logic [depth:0]     ram_addr,
    output logic [3:0]         ram_data_out,
    input  logic [3:0]         ram_data_read,
    input  logic               ram_ready,
    output logic [x_width:0]   off_x,
    output logic [x_width:0]   off_y,
    output logic [x_width:0]   max_off_x,
    output logic [x_width:0]   max_off_y,
    output logic [x_width:0]   last_x,
    output logic [x_width:0]   last_y,
    output logic               move_valid,
    input  logic               move_ready,
    output logic [x_width:0]   move_x,
    output logic [x_width:0]   move_y,
    output logic [3:0]         move_t,
    output logic               reject,
    output logic [15:0]        move_count
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WRITE,
        UPDATE,
        REPORT
    } state_t;

    localparam logic [x_width:0] INIT = (x_width+1)'(init_off);

    state_t state_q, state_d;

    logic [x_width:0] mx_q, mx_d, my_q, my_d;
    logic [3:0]       mt_q, mt_d;
    logic             busy_q, busy_d;
    logic             rd_en_q, rd_en_d;
    logic             wr_en_q, wr_en_d;
    logic [depth:0]   addr_q, addr_d;
    logic [3:0]       wdata_q, wdata_d;
    logic [x_width:0] off_x_q, off_x_d, off_y_q, off_y_d;
    logic [x_width:0] max_x_q, max_x_d, max_y_q, max_y_d;
    logic [x_width:0] last_x_q, last_x_d, last_y_q, last_y_d;
    logic             valid_q, valid_d;
    logic [x_width:0] mv_x_q, mv_x_d, mv_y_q, mv_y_d;
    logic [3:0]       mv_t_q, mv_t_d;
    logic             reject_q, reject_d;
    logic [15:0]      count_q, count_d;

    // Next-state and registered-output computation for the commit sequence
    always_comb begin
        state_d  = state_q;
        mx_d     = mx_q;
        my_d     = my_q;
        mt_d     = mt_q;
        rd_en_d  = rd_en_q;
        wr_en_d  = wr_en_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        off_x_d  = off_x_q;
        off_y_d  = off_y_q;
        max_x_d  = max_x_q;
        max_y_d  = max_y_q;
        last_x_d = last_x_q;
        last_y_d = last_y_q;
        valid_d  = valid_q;
        mv_x_d   = mv_x_q;
        mv_y_d   = mv_y_q;
        mv_t_d   = mv_t_q;
        reject_d = 1'b0;
        count_d  = count_q;

        unique case (state_q)
            IDLE: begin
                if (w_end) begin
                    mx_d    = in_x;
                    my_d    = in_y;
                    mt_d    = in_t;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (mt_q == 4'd0) begin
                    reject_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    addr_d  = {my_q, mx_q};
                    rd_en_d = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (ram_ready) begin
                    rd_en_d = 1'b0;
                    if (ram_data_read != 4'd0) begin
                        reject_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        wr_en_d = 1'b1;
                        wdata_d = mt_q;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (ram_ready) begin
                    wr_en_d = 1'b0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                if (mx_q < off_x_q) off_x_d = mx_q;
                if (my_q < off_y_q) off_y_d = my_q;
                if (mx_q > max_x_q) max_x_d = mx_q;
                if (my_q > max_y_q) max_y_d = my_q;
                last_x_d = mx_q;
                last_y_d = my_q;
                if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                valid_d  = 1'b1;
                mv_x_d   = mx_q;
                mv_y_d   = my_q;
                mv_t_d   = mt_q;
                state_d  = REPORT;
            end
            REPORT: begin
                if (move_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mx_q     <= '0;
            my_q     <= '0;
            mt_q     <= '0;
            busy_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            off_x_q  <= INIT;
            off_y_q  <= INIT;
            max_x_q  <= INIT;
            max_y_q  <= INIT;
            last_x_q <= INIT;
            last_y_q <= INIT;
            valid_q  <= 1'b0;
            mv_x_q   <= '0;
            mv_y_q   <= '0;
            mv_t_q   <= '0;
            reject_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            mt_q     <= mt_d;
            busy_q   <= busy_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            off_x_q  <= off_x_d;
            off_y_q  <= off_y_d;
            max_x_q  <= max_x_d;
            max_y_q  <= max_y_d;
            last_x_q <= last_x_d;
            last_y_q <= last_y_d;
            valid_q  <= valid_d;
            mv_x_q   <= mv_x_d;
            mv_y_q   <= mv_y_d;
            mv_t_q   <= mv_t_d;
            reject_q <= reject_d;
            count_q  <= count_d;
        end
    end

    assign array_busy   = busy_q;
    assign ram_rd_en    = rd_en_q;
    assign ram_write_en = wr_en_q;
    assign ram_addr     = addr_q;
    assign ram_data_out = wdata_q;
    assign off_x        = off_x_q;
    assign off_y        = off_y_q;
    assign max_off_x    = max_x_q;
    assign max_off_y    = max_y_q;
    assign last_x       = last_x_q;
    assign last_y       = last_y_q;
    assign move_valid   = valid_q;
    assign move_x       = mv_x_q;
    assign move_y       = mv_y_q;
    assign move_t       = mv_t_q;
    assign reject       = reject_q;
    assign move_count   = count_q;

endmodule

// File: doc/move_commit.md
Name: move_commit

Overview:
- Consumer end of the move-selection handshake. Accepts a selected move (x, y, tile) on a one-cycle w_end pulse and raises array_busy while it works.
- Checks the target board cell in board RAM, writes the tile if the cell is empty, and updates the board bounding box and last-move registers.
- Presents the committed move to the host link, then releases array_busy.
- Sits between the selector and board RAM / host interface; its bounds outputs feed the selector's start-time snapshot.

Parameters:
- x_width, 10: coordinate MSB index (coordinates are x_width+1 bits).
- depth, 21: RAM address MSB index; must equal 2*x_width+1.
- init_off, 32: reset value of all bounds and last-move registers.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- w_end  in  1  one-cycle pulse: move on in_x/in_y/in_t valid
- in_x, in_y  in  x_width+1 each  move coordinates
- in_t  in  4  tile code; 0 = empty/illegal
- array_busy  out  1  high while a move is being committed
- ram_rd_en  out  1  read request
- ram_write_en  out  1  write request
- ram_addr  out  depth+1  {y,x}
- ram_data_out  out  4  tile to write
- ram_data_read  in  4  read data, valid when ram_ready=1 during a read
- ram_ready  in  1  RAM completion strobe
- off_x, off_y, max_off_x, max_off_y  out  x_width+1 each  bounding box min/max
- last_x, last_y  out  x_width+1 each  last committed cell
- move_valid  out  1  host handshake valid
- move_ready  in  1  host handshake ready
- move_x, move_y  out  x_width+1 each  committed move coordinates
- move_t  out  4  committed move tile
- reject  out  1  one-cycle pulse: move refused
- move_count  out  16  committed moves, saturating

Behaviour:
- Reset values:
  - State IDLE; array_busy, ram_rd_en, ram_write_en, move_valid and reject all 0.
  - ram_addr = 0, ram_data_out = 0, move_x/y/t = 0, move_count = 0.
  - off_x, off_y, max_off_x, max_off_y, last_x, last_y = init_off.
- IDLE:
  - On w_end=1, latch in_x/in_y/in_t into mx/my/mt and go to RD_REQ.
  - array_busy=1 from the next cycle (registered) until the cycle after re-entering IDLE.
  - w_end is ignored while not in IDLE; no queueing.
- RD_REQ:
  - If mt==0, pulse reject and go to IDLE without any RAM access.
  - Otherwise drive ram_addr={my,mx} and ram_rd_en=1, then go to RD_WAIT.
- RD_WAIT:
  - Hold ram_rd_en=1 and ram_addr until ram_ready=1 is sampled.
  - If ram_data_read!=0 (cell occupied), pulse reject and go to IDLE.
  - Otherwise go to WRITE.
- WRITE:
  - Drive ram_write_en=1, ram_addr={my,mx}, ram_data_out=mt.
  - Hold until ram_ready=1 is sampled; ram_write_en drops the following cycle. Go to UPDATE.
- UPDATE (single cycle):
  - off_x=min(off_x,mx), off_y=min(off_y,my).
  - max_off_x=max(max_off_x,mx), max_off_y=max(max_off_y,my).
  - last_x=mx, last_y=my.
  - move_count+1, saturating at 16'hFFFF.
  - Comparisons are unsigned. Go to REPORT.
- REPORT:
  - move_valid=1 with move_x/y/t = mx/my/mt, held stable until move_ready=1.
  - The transfer occurs in the cycle where valid and ready are both 1. move_valid drops the next cycle; go to IDLE.
  - move_ready already high on REPORT entry completes the transfer in one cycle.
- Minimum latency: w_end to return to IDLE is 6 cycles with ram_ready=1 and move_ready=1 held.
- Bounds never shrink. An update where mx equals the current min or max leaves that register unchanged.
- Reset mid-operation:
  - All outputs return to reset values next edge; RAM enables drop immediately.
  - Any partial write is the RAM's concern; bounds are not updated.
- ram_ready seen outside RD_WAIT/WRITE is ignored.
- reject and a commit are mutually exclusive per move. move_count is unchanged on reject.

Test Plan:
- Reset, then w_end with x=33, y=30, t=3, RAM reads 0, ram_ready=1 each request -> write addr {30,33} data 3. Bounds become off_x=32, off_y=30, max_off_x=33, max_off_y=32; last=(33,30); move_count=1; move_valid with (33,30,3); array_busy low after handshake.
- Same cell again with RAM read returning 3 -> reject pulse, no ram_write_en, bounds and count unchanged.
- w_end with t=0 -> reject within 2 cycles, ram_rd_en never asserted.
- ram_ready delayed 5 cycles on the read and 3 on the write, move_ready delayed 4 cycles -> ram_addr, ram_rd_en, ram_write_en and move_* held stable throughout; array_busy continuous; a second w_end pulse mid-operation is ignored.
- Reset asserted during WRITE wait -> next cycle ram_write_en=0, array_busy=0, bounds=32, move_count=0.
- move_count preloaded near saturation via 65535 commits (or force) -> stays 16'hFFFF on a further commit.
